// File: rtl/master_trigger_generator_if.sv
// Trigger-link bundle between a timer's control logic and its TRGO generator.
// The master modport is the generator's view: it consumes the control
// signals and drives trg/trg_edge. The slave modport is the opposite side.
interface master_trigger_generator_if #(
  parameter int unsigned CH_PAIRS_NUM = 2
);

  logic [2:0]                  mms;        // master mode select
  logic                        dly;        // one extra cycle of trg latency
  logic                        ug;         // software update generation pulse
  logic                        cnt_en;     // counter enable level
  logic                        uev;        // update event pulse
  logic                        cc1_match;  // CC1 match pulse
  logic [2*CH_PAIRS_NUM-1:0]   ocref;      // OCxREF levels, bit k = channel k+1
  logic                        trg;        // TRGO to slave timers
  logic                        trg_edge;   // one-cycle pulse per rising edge of trg

  modport master (
    input  mms,
    input  dly,
    input  ug,
    input  cnt_en,
    input  uev,
    input  cc1_match,
    input  ocref,
    output trg,
    output trg_edge
  );

  modport slave (
    output mms,
    output dly,
    output ug,
    output cnt_en,
    output uev,
    output cc1_match,
    output ocref,
    input  trg,
    input  trg_edge
  );

endinterface

// File: rtl/master_trigger_generator.sv
// Master-mode TRGO transmitter for the inter-timer trigger link.
// Selects a timer event or level according to the master mode select,
// shapes it (single pulse, stretched pulse or level), optionally adds one
// cycle of latency, and drives trg plus a registered rising-edge strobe.
//
// Build option: define TRGO_STRETCH_EN to stretch pulse-mode events to
// PULSE_W cycles (with retrigger). Without it, every pulse-mode event gives
// exactly one high cycle and no stretch counter exists.
module master_trigger_generator #(
  parameter int unsigned CH_PAIRS_NUM = 2,
  parameter int unsigned PULSE_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        aresetn_i,
  master_trigger_generator_if.master  bus
);

  localparam int unsigned OCREF_NUM = 2 * CH_PAIRS_NUM;
  // mms[1:0] can only address the first four OCxREF channels.
  localparam int unsigned OCREF_SEL = (OCREF_NUM < 4) ? OCREF_NUM : 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_LEVEL
  } state_e;

  state_e      state;
  logic [2:0]  mms_q;       // mode seen on the previous edge
  logic        stage_q;     // FSM stage output, also the extra-latency register
  logic        trg_q;       // registered TRGO
  logic        trg_d;       // trg one cycle later, for edge detection
  logic        trg_edge_q;  // registered rising-edge strobe

  logic        guard;       // mode is changing on this edge
  logic        pulse_mode;  // selected source is an event pulse
  logic        src;         // selected source value this cycle
  logic        stretch_on;  // stretch counter still holding the pulse high
  logic        stage_nxt;   // stage output to be registered on this edge

`ifdef TRGO_STRETCH_EN
  localparam int unsigned CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

  logic [CNT_W-1:0] cnt;    // remaining stretched cycles after the current one
`else
  // PULSE_W has no effect in this build; it stays on the port list so both
  // builds share one parameter set.
  if (PULSE_W == 0) begin : g_pulse_w_unused
  end
`endif

  // Source selection and output decode for the shaping stage.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
    src        = 1'b0;
    pulse_mode = 1'b0;
    stretch_on = 1'b0;
    guard      = (bus.mms != mms_q);

    unique casez (bus.mms)
      3'b000: begin src = bus.ug;        pulse_mode = 1'b1; end
      3'b001: begin src = bus.cnt_en;    pulse_mode = 1'b0; end
      3'b010: begin src = bus.uev;       pulse_mode = 1'b1; end
      3'b011: begin src = bus.cc1_match; pulse_mode = 1'b1; end
      3'b1??: begin
        // Channels beyond the implemented OCxREF set read as 0.
        for (int k = 0; k < int'(OCREF_SEL); k++) begin
          if (bus.mms[1:0] == 2'(k)) begin
            src = bus.ocref[k];
          end
        end
      end
      default: begin src = 1'b0; pulse_mode = 1'b0; end
    endcase

`ifdef TRGO_STRETCH_EN
    stretch_on = (state == ST_PULSE) && (cnt != '0);
`endif

    // In every state the stage is high when the selected source is active;
    // a pending stretch keeps it high between events.
    stage_nxt = guard ? 1'b0 : (src | stretch_on);
  end

  // Shaping FSM with registered stage, TRGO and mode-change guard.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state   <= ST_IDLE;
      mms_q   <= 3'b000;
      stage_q <= 1'b0;
      trg_q   <= 1'b0;
`ifdef TRGO_STRETCH_EN
      cnt     <= '0;
`endif
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values and order does not matter.
      mms_q <= bus.mms;

      if (guard) begin
        // A mode switch flushes everything so no stale level or pulse can
        // leak into the new mode as a false edge.
        state   <= ST_IDLE;
        stage_q <= 1'b0;
        trg_q   <= 1'b0;
`ifdef TRGO_STRETCH_EN
        cnt     <= '0;
`endif
      end else begin
        stage_q <= stage_nxt;
        // With dly set, TRGO takes the already-registered stage value,
        // adding exactly one cycle of latency.
        trg_q   <= bus.dly ? stage_q : stage_nxt;

        unique case (state)
          ST_IDLE: begin
            if (src) begin
              state <= pulse_mode ? ST_PULSE : ST_LEVEL;
`ifdef TRGO_STRETCH_EN
              cnt   <= CNT_LOAD;
`endif
            end
          end

          ST_PULSE: begin
`ifdef TRGO_STRETCH_EN
            // A new event reloads the counter, so the output never gaps.
            if (src) begin
              cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= ST_IDLE;
            end
`else
            // One high cycle per event; back-to-back events keep it high.
            if (!src) begin
              state <= ST_IDLE;
            end
`endif
          end

          ST_LEVEL: begin
            if (!src) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Rising-edge strobe on TRGO, one cycle after trg rises.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      trg_d      <= 1'b0;
      trg_edge_q <= 1'b0;
    end else begin
      trg_d      <= trg_q;
      trg_edge_q <= trg_q & ~trg_d;
    end
  end

  assign bus.trg      = trg_q;
  assign bus.trg_edge = trg_edge_q;

endmodule

// File: tb/tb_master_trigger_generator.sv
// Self-checking bench for master_trigger_generator.
// Directed scenarios followed by a randomized phase, all compared against a
// cycle-level behavioural model of TRGO derived from the mode rules.
module tb_master_trigger_generator;

  localparam int unsigned CH_PAIRS_NUM = 2;
  localparam int unsigned PULSE_W      = 4;
`ifdef TRGO_STRETCH_EN
  localparam int PW = PULSE_W;
`else
  localparam int PW = 1;
`endif

  logic clk;
  logic rst_n;

  master_trigger_generator_if #(.CH_PAIRS_NUM(CH_PAIRS_NUM)) bus ();

  master_trigger_generator #(
    .CH_PAIRS_NUM (CH_PAIRS_NUM),
    .PULSE_W      (PULSE_W)
  ) dut (
    .clk_i     (clk),
    .aresetn_i (rst_n),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int         rem;        // stretched cycles still owed to the current pulse
  logic       s_prev;     // shaped value of the previous cycle
  logic       trg_m;      // expected trg
  logic       trg_d_m;    // expected trg one cycle earlier
  logic       edge_m;     // expected trg_edge
  logic [2:0] mms_prev;   // mode in force on the previous cycle
  int         hi_cnt;     // expected-high cycles seen since last clear
  int         edge_cnt;   // observed edge strobes since last clear

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rem      = 0;
    s_prev   = 1'b0;
    trg_m    = 1'b0;
    trg_d_m  = 1'b0;
    edge_m   = 1'b0;
    mms_prev = 3'b000;
  endtask

  function automatic logic model_src(input logic [2:0] m);
    int idx;
    case (m)
      3'b000:  return bus.ug;
      3'b001:  return bus.cnt_en;
      3'b010:  return bus.uev;
      3'b011:  return bus.cc1_match;
      default: begin
        idx = int'(m[1:0]);
        if (idx < 2 * int'(CH_PAIRS_NUM)) return bus.ocref[idx];
        return 1'b0;
      end
    endcase
  endfunction

  // One clock: predict from current inputs, clock, then compare.
  task automatic step();
    logic       g;
    logic       s;
    logic       src;
    logic       nt;
    logic       ne;
    logic [2:0] m;
    m   = bus.mms;
    g   = (m != mms_prev);
    src = model_src(m);
    if (g) begin
      s   = 1'b0;
      rem = 0;
    end else if (m == 3'b000 || m == 3'b010 || m == 3'b011) begin
      if (src) rem = PW;
      s = (rem > 0);
      if (rem > 0) rem--;
    end else begin
      s = src;
    end
    nt = g ? 1'b0 : (bus.dly ? s_prev : s);
    ne = trg_m & ~trg_d_m;
    @(posedge clk);
    #1;
    trg_d_m  = trg_m;
    trg_m    = nt;
    edge_m   = ne;
    s_prev   = s;
    mms_prev = m;
    if (trg_m) hi_cnt++;
    if (bus.trg_edge === 1'b1) edge_cnt++;
    chk("trg", bus.trg, trg_m);
    chk("trg_edge", bus.trg_edge, edge_m);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mms       = 3'b100;
    bus.dly       = 1'b0;
    bus.ug        = 1'b0;
    bus.cnt_en    = 1'b0;
    bus.uev       = 1'b0;
    bus.cc1_match = 1'b0;
    bus.ocref     = 4'hF;
    rst_n         = 1'b0;
    model_reset();
    hi_cnt   = 0;
    edge_cnt = 0;

    // Reset state with a level source already active
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trg", bus.trg, 1'b0);
    chk("rst_edge", bus.trg_edge, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rst_guard_cycle", bus.trg, 1'b0);
    step();
    chk("rst_level_after_2", bus.trg, 1'b1);
    idle_steps(2);

    // UEV pulse, no extra latency
    bus.mms = 3'b010;
    bus.dly = 1'b0;
    idle_steps(4);
    hi_cnt   = 0;
    edge_cnt = 0;
    bus.uev  = 1'b1;
    step();
    bus.uev  = 1'b0;
    chk("uev_first_high", bus.trg, 1'b1);
    idle_steps(8);
    chk("uev_width", hi_cnt, PW);
    chk("uev_edges", edge_cnt, 1);

    // UG pulse with one extra cycle of latency
    bus.mms = 3'b000;
    bus.dly = 1'b1;
    idle_steps(5);
    bus.ug  = 1'b1;
    step();
    bus.ug  = 1'b0;
    chk("ug_dly_n1", bus.trg, 1'b0);
    step();
    chk("ug_dly_n2", bus.trg, 1'b1);
    idle_steps(6);

    // CC1 retrigger: events two cycles apart
    bus.mms = 3'b011;
    bus.dly = 1'b0;
    idle_steps(4);
    hi_cnt   = 0;
    edge_cnt = 0;
    bus.cc1_match = 1'b1; step();
    bus.cc1_match = 1'b0; step();
    bus.cc1_match = 1'b1; step();
    bus.cc1_match = 1'b0;
    idle_steps(8);
    chk("retrig_high_cycles", hi_cnt, (PW >= 2) ? PW + 2 : 2);
    chk("retrig_edges", edge_cnt, (PW >= 2) ? 1 : 2);

    // Counter-enable level, then switch to OC4REF mid-level
    bus.mms   = 3'b001;
    bus.ocref = 4'b1000;
    idle_steps(3);
    bus.cnt_en = 1'b1;
    idle_steps(3);
    chk("level_high", bus.trg, 1'b1);
    bus.mms = 3'b111;
    step();
    chk("mode_switch_guard", bus.trg, 1'b0);
    step();
    chk("mode_switch_new_src", bus.trg, 1'b1);
    step();
    bus.cnt_en = 1'b0;
    bus.ocref  = 4'b0000;
    idle_steps(4);

    // Asynchronous reset in the middle of a stretched pulse
    bus.mms = 3'b011;
    idle_steps(3);
    bus.cc1_match = 1'b1; step();
    bus.cc1_match = 1'b0; step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_trg", bus.trg, 1'b0);
    chk("midrst_edge", bus.trg_edge, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hi_cnt = 0;
    idle_steps(8);
    chk("midrst_no_resume", hi_cnt, 0);

    // Randomized traffic across all modes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.mms = 3'($urandom_range(0, 7));
        bus.dly = 1'($urandom_range(0, 1));
      end
      bus.ug        = ($urandom_range(0, 3) == 0);
      bus.uev       = ($urandom_range(0, 3) == 0);
      bus.cc1_match = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bus.cnt_en = ~bus.cnt_en;
      if ($urandom_range(0, 3) == 0) bus.ocref[$urandom_range(0, 3)] = 1'($urandom_range(0, 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
